// File: rtl/alu_uart_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_uart_ctrl_pkg
// Shared definitions for the ALU byte-stream sequencer:
//   - ALU opcode constants (6-bit)
//   - bit positions of the flag byte returned to the host
//   - controller state encoding (3 bits)
// ---------------------------------------------------------------------------
package alu_uart_ctrl_pkg;

    localparam int ALU_WOP = 6;

    localparam logic [ALU_WOP-1:0] OP_ADD = 6'b100000;
    localparam logic [ALU_WOP-1:0] OP_SUB = 6'b100010;
    localparam logic [ALU_WOP-1:0] OP_AND = 6'b100100;
    localparam logic [ALU_WOP-1:0] OP_OR  = 6'b100101;
    localparam logic [ALU_WOP-1:0] OP_XOR = 6'b100110;
    localparam logic [ALU_WOP-1:0] OP_NOR = 6'b100111;
    localparam logic [ALU_WOP-1:0] OP_SRL = 6'b000010;
    localparam logic [ALU_WOP-1:0] OP_SRA = 6'b000011;

    // Position of each ALU flag inside the transmitted flag byte.
    localparam int FLAG_CARRY    = 4;
    localparam int FLAG_BORROW   = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_NEG      = 0;
    localparam int NUM_FLAGS     = 5;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND_Y  = 3'd4,
        ST_WAIT_Y  = 3'd5,
        ST_SEND_F  = 3'd6,
        ST_WAIT_F  = 3'd7
    } ctrl_state_t;

    // States in which an incoming byte is part of the command being collected.
    function automatic logic is_rx_state(input ctrl_state_t s);
        return (s == ST_WAIT_A) || (s == ST_WAIT_B) || (s == ST_WAIT_OP);
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_uart_ctrl_if
// Bundle of the UART RX/TX handshakes, the ALU operand/result bus and the
// status outputs of the sequencer.
//   master : the sequencer (alu_uart_ctrl)
//   slave  : the surroundings (UART RX/TX, ALU, status consumer)
// Signals:
//   rx_valid/rx_data     received byte strobe and data
//   tx_start/tx_data     transmit request and byte, tx_done completion pulse
//   alu_a/alu_b/alu_op   registered ALU inputs; alu_y/alu_flags ALU outputs
//   busy, err_timeout, err_overrun  status
// ---------------------------------------------------------------------------
interface alu_uart_ctrl_if #(
    parameter int W   = 8,
    parameter int WOP = 6
);
    logic           rx_valid;
    logic [W-1:0]   rx_data;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_done;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [WOP-1:0] alu_op;
    logic [W-1:0]   alu_y;
    logic [4:0]     alu_flags;
    logic           busy;
    logic           err_timeout;
    logic           err_overrun;

    modport master (
        input  rx_valid, rx_data, tx_done, alu_y, alu_flags,
        output tx_start, tx_data, alu_a, alu_b, alu_op,
               busy, err_timeout, err_overrun
    );

    modport slave (
        output rx_valid, rx_data, tx_done, alu_y, alu_flags,
        input  tx_start, tx_data, alu_a, alu_b, alu_op,
               busy, err_timeout, err_overrun
    );
endinterface

// File: rtl/alu_uart_ctrl_byte_timeout.sv
// ---------------------------------------------------------------------------
// byte_timeout
// Loadable down-counter guarding the gap between bytes of one command.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_load      reload the counter (a byte was accepted)
//   i_en        one idle cycle is being spent in a guarded state
//   o_expired   the current idle cycle is the TIMEOUT-th one in a row
// TIMEOUT = 0 removes the counter; o_expired is then constant 0.
// ---------------------------------------------------------------------------
module byte_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [CW-1:0] r_cnt;

            // Loaded with TIMEOUT-1 so that the count reads 0 during the
            // TIMEOUT-th consecutive idle cycle after the load.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (i_load) begin
                    r_cnt <= CW'(TIMEOUT - 1);
                end else if (i_en && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign o_expired = i_en && (r_cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/alu_uart_ctrl.sv
// ---------------------------------------------------------------------------
// alu_uart_ctrl
// Sequencer between UART RX/TX and a combinational 8-bit ALU. Collects
// operand A, operand B and opcode from the RX byte stream, lets the ALU
// settle for one cycle, then sends the result byte and the flag byte back
// over UART TX.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    alu_uart_ctrl_if.master (RX/TX handshakes, ALU bus, status)
// ---------------------------------------------------------------------------
import alu_uart_ctrl_pkg::*;

module alu_uart_ctrl #(
    parameter int W       = 8,
    parameter int WOP     = 6,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_uart_ctrl_if.master  bus
);

    ctrl_state_t    r_state;
    ctrl_state_t    w_state_next;

    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [WOP-1:0] r_alu_op;
    logic [W-1:0]   r_tx_data;
    logic [W-1:0]   r_res_f;
    logic           r_err_timeout;
    logic           r_err_overrun;

    logic           w_rx_state;
    logic           w_accept;
    logic           w_overrun;
    logic           w_to_en;
    logic           w_to_expired;
    logic           w_tx_start;
    logic           w_busy;
    logic [W-1:0]   w_res_f;

    // Flag byte: each ALU flag placed at its documented bit, upper bits zero.
    always_comb begin
        w_res_f                = '0;
        w_res_f[FLAG_CARRY]    = bus.alu_flags[4];
        w_res_f[FLAG_BORROW]   = bus.alu_flags[3];
        w_res_f[FLAG_OVERFLOW] = bus.alu_flags[2];
        w_res_f[FLAG_ZERO]     = bus.alu_flags[1];
        w_res_f[FLAG_NEG]      = bus.alu_flags[0];
    end

    assign w_rx_state = is_rx_state(r_state);
    assign w_accept   = bus.rx_valid && w_rx_state;
    assign w_overrun  = bus.rx_valid && !w_rx_state;
    // A byte arriving in the expiry cycle suppresses the count, so it wins.
    assign w_to_en    = ((r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP)) && !bus.rx_valid;

    byte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_byte_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_en      (w_to_en),
        .o_expired (w_to_expired)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_A:  if (bus.rx_valid) w_state_next = ST_WAIT_B;
            ST_WAIT_B: begin
                if (bus.rx_valid)      w_state_next = ST_WAIT_OP;
                else if (w_to_expired) w_state_next = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (bus.rx_valid)      w_state_next = ST_EXEC;
                else if (w_to_expired) w_state_next = ST_WAIT_A;
            end
            ST_EXEC:    w_state_next = ST_SEND_Y;
            ST_SEND_Y:  w_state_next = ST_WAIT_Y;
            ST_WAIT_Y:  if (bus.tx_done) w_state_next = ST_SEND_F;
            ST_SEND_F:  w_state_next = ST_WAIT_F;
            ST_WAIT_F:  if (bus.tx_done) w_state_next = ST_WAIT_A;
            default:    w_state_next = ST_WAIT_A;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_tx_start = (r_state == ST_SEND_Y) || (r_state == ST_SEND_F);
        w_busy     = (r_state != ST_WAIT_A);
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= '0;
            r_tx_data     <= '0;
            r_res_f       <= '0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_timeout <= w_to_expired;
            r_err_overrun <= w_overrun;

            if (bus.rx_valid) begin
                if (r_state == ST_WAIT_A)  r_alu_a  <= bus.rx_data;
                if (r_state == ST_WAIT_B)  r_alu_b  <= bus.rx_data;
                if (r_state == ST_WAIT_OP) r_alu_op <= bus.rx_data[WOP-1:0];
            end

            // The TX data register doubles as the result capture: it is
            // loaded with alu_y at the end of EXEC and stays put until the
            // result byte's tx_done, when the saved flag byte replaces it.
            if (r_state == ST_EXEC) begin
                r_tx_data <= bus.alu_y;
                r_res_f   <= w_res_f;
            end else if ((r_state == ST_WAIT_Y) && bus.tx_done) begin
                r_tx_data <= r_res_f;
            end
        end
    end

    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_start    = w_tx_start;
    assign bus.busy        = w_busy;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_overrun = r_err_overrun;

endmodule
